// File: rtl/multicycle_control_unit.sv
// Multicycle ARM-subset control unit: FETCH/DECODE/EXECUTE/MEM/WB sequencer,
// ALU decoder, condition check and NZCV flags register.
module multicycle_control_unit #(
    parameter int unsigned ALUCTRL_W   = 2,
    parameter bit          COND_FULL   = 1'b1,
    parameter bit          SUPPORT_CMP = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           Rd,
    input  logic [1:0]           Op,
    input  logic [5:0]           Funct,
    input  logic [3:0]           Cond,
    input  logic [3:0]           ALUFlags,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [3:0]           State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    state_t               state_q, state_d, out_state;
    logic [3:0]           flags_q, flags_d;
    logic                 condexr_q, condexr_d;
    logic                 condex;
    logic [ALUCTRL_W-1:0] alu_dec;
    logic                 nowrite;
    logic [1:0]           flagw;
    logic                 regw, memw, nextpc, branch, is_exec;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            flags_q   <= '0;
            condexr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            condexr_q <= condexr_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    2'b01:   state_d = S_MEMADR;
                    2'b00:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = flags_q;
        condex = 1'b0;
        case (Cond)
            4'b0000: condex = z;
            4'b0001: condex = ~z;
            4'b0010: condex = COND_FULL & c;
            4'b0011: condex = COND_FULL & ~c;
            4'b0100: condex = COND_FULL & n;
            4'b0101: condex = COND_FULL & ~n;
            4'b0110: condex = COND_FULL & v;
            4'b0111: condex = COND_FULL & ~v;
            4'b1000: condex = COND_FULL & c & ~z;
            4'b1001: condex = COND_FULL & (~c | z);
            4'b1010: condex = COND_FULL & (n == v);
            4'b1011: condex = COND_FULL & (n != v);
            4'b1100: condex = COND_FULL & ~z & (n == v);
            4'b1101: condex = COND_FULL & (z | (n != v));
            default: condex = 1'b1;
        endcase
    end

    // Predication is latched in DECODE so the instruction's own flag update can't gate it.
    assign condexr_d = (state_q == S_DECODE) ? condex : condexr_q;
    assign is_exec   = (state_q == S_EXECUTER) || (state_q == S_EXECUTEI);

    always_comb begin
        flags_d = flags_q;
        if (is_exec && condexr_q) begin
            if (flagw[1]) flags_d[3:2] = ALUFlags[3:2];
            if (flagw[0]) flags_d[1:0] = ALUFlags[1:0];
        end
    end

    always_comb begin
        alu_dec = '0;
        nowrite = 1'b1;
        flagw   = 2'b00;
        case (Funct[4:1])
            4'b0100: begin alu_dec = ALUCTRL_W'(0); nowrite = 1'b0; flagw = {2{Funct[0]}}; end
            4'b0010: begin alu_dec = ALUCTRL_W'(1); nowrite = 1'b0; flagw = {2{Funct[0]}}; end
            4'b0000: begin alu_dec = ALUCTRL_W'(2); nowrite = 1'b0; flagw = {Funct[0], 1'b0}; end
            4'b1100: begin alu_dec = ALUCTRL_W'(3); nowrite = 1'b0; flagw = {Funct[0], 1'b0}; end
            4'b0001: if (ALUCTRL_W >= 3) begin
                alu_dec = ALUCTRL_W'(4); nowrite = 1'b0; flagw = {Funct[0], 1'b0};
            end
            4'b1010: if (SUPPORT_CMP) begin
                alu_dec = ALUCTRL_W'(1); nowrite = 1'b1; flagw = 2'b11;
            end
            default: ;
        endcase
    end

    // Reset decodes as FETCH so the mux selects settle while enables are held low.
    assign out_state = rst ? S_FETCH : state_q;

    always_comb begin
        regw       = 1'b0;
        memw       = 1'b0;
        nextpc     = 1'b0;
        branch     = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = '0;
        case (out_state)
            S_FETCH: begin
                IRWrite = 1'b1; nextpc = 1'b1;
                ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
            end
            S_MEMADR:   ALUSrcB = 2'b01;
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB:    begin ResultSrc = 2'b01; regw = 1'b1; end
            S_MEMWRITE: begin AdrSrc = 1'b1; memw = 1'b1; end
            S_EXECUTER: ALUControl = alu_dec;
            S_EXECUTEI: begin ALUSrcB = 2'b01; ALUControl = alu_dec; end
            S_ALUWB:    regw = ~nowrite;
            S_BRANCH: begin
                ALUSrcB = 2'b01; ResultSrc = 2'b10; branch = 1'b1;
            end
            default: ;
        endcase
        if (rst) IRWrite = 1'b0;
    end

    assign RegWrite = ~rst & regw & condexr_q & (Rd != 4'd15);
    assign MemWrite = ~rst & memw & condexr_q;
    assign PCWrite  = ~rst & (nextpc | (branch & condexr_q) |
                              (regw & condexr_q & (Rd == 4'd15)));
    assign ImmSrc   = Op;
    assign RegSrc   = {Op == 2'b01, Op == 2'b10};
    assign State    = state_q;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Control unit for the multicycle ARM-subset processor: a state machine sequences fetch, decode, execute, memory and writeback over 3–5 cycles per instruction.
- Drives the shared-memory datapath: PC, IR, ALU source muxes, result mux and register file.
- Contains the condition-check logic and the NZCV flags register.
- Generalises the single-cycle controller: ALU-control width is parametrised, the full condition-code set is selectable, and CMP/no-write support is optional.

Parameters:
- ALUCTRL_W, 2, ALUControl width; 2 gives ADD/SUB/AND/ORR, 3 or more adds EOR.
- COND_FULL, 1, 1 = all ARM condition codes; 0 = EQ, NE, AL (and 1111) only.
- SUPPORT_CMP, 1, 1 = decode CMP (flags only, no register write); 0 = CMP treated as unsupported.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- Rd  in  4  Instr[15:12]
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]
- Cond  in  4  Instr[31:28]
- ALUFlags  in  4  NZCV from ALU, current cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction register enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  result mux: 00 = ALUOut reg, 01 = Data reg, 10 = ALU direct
- ALUSrcA  out  2  ALU A mux: 00 = RD1 reg, 01 = PC
- ALUSrcB  out  2  ALU B mux: 00 = RD2 reg, 01 = ExtImm, 10 = constant 4
- ImmSrc  out  2  equals Op
- RegSrc  out  2  [0] = (Op==10), [1] = (Op==01); combinational
- ALUControl  out  ALUCTRL_W  ALU operation
- State  out  4  current state encoding, for debug

Behaviour:
Reset (synchronous):
- On a clk edge with rst=1: state ← FETCH, Flags ← 0000, CondExR ← 0.
- While rst=1, PCWrite, IRWrite, RegWrite and MemWrite are forced 0; mux selects take their FETCH values.
- rst asserted in any state aborts the instruction; no write enable is asserted in that cycle.

States (encoding; asserted signals; next state). Signals not listed are 0 / 00.
- FETCH (0): IRWrite=1, NextPC=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ADD; → DECODE.
- DECODE (1): ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - Next state: Op=01 → MEMADR; Op=00 with Funct[5]=0 → EXECUTER; Op=00 with Funct[5]=1 → EXECUTEI; Op=10 → BRANCH; Op=11 → FETCH (NOP).
- MEMADR (2): ALUSrcB=01, ADD; Funct[0]=1 → MEMREAD, otherwise → MEMWRITE.
- MEMREAD (3): AdrSrc=1; → MEMWB.
- MEMWB (4): ResultSrc=01, RegW=1; → FETCH.
- MEMWRITE (5): AdrSrc=1, MemW=1; → FETCH.
- EXECUTER (6): ALUSrcB=00, ALU op decoded; → ALUWB.
- EXECUTEI (7): ALUSrcB=01, ALU op decoded; → ALUWB.
- ALUWB (8): ResultSrc=00, RegW = !NoWrite; → FETCH.
- BRANCH (9): ALUSrcB=01, ResultSrc=10, Branch=1, ADD; → FETCH.
- Latency: branch 3 cycles; data processing and STR 4 cycles; LDR 5 cycles.
- Encodings 10–15 are illegal; the FSM goes to FETCH on the next edge.

ALU decode (Funct[4:1] = cmd), in execute states only:
- 0100 ADD → 00.
- 0010 SUB → 01.
- 0000 AND → 10.
- 1100 ORR → 11.
- 0001 EOR → 100, only when ALUCTRL_W ≥ 3.
- 1010 CMP → SUB with NoWrite=1, only when SUPPORT_CMP=1.
- Any other cmd: ALUControl=0, NoWrite=1, FlagW=00 (NOP).

Flag write mask:
- FlagW[1] (updates N, Z) = Funct[0] for all supported cmds, and 1 for CMP.
- FlagW[0] (updates C, V) = Funct[0] for ADD/SUB only, and 1 for CMP.

Condition logic:
- CondEx is computed combinationally from Cond and the Flags register, using standard ARM semantics.
- Cond=1110 → 1; Cond=1111 → 1.
- With COND_FULL=0, any Cond other than 0000, 0001, 1110, 1111 evaluates to 0.
- CondExR ← CondEx on the edge leaving DECODE. All gating below uses CondExR, so a flag update from the same instruction never changes its own predication.
- Flags update on the edge leaving EXECUTER/EXECUTEI, only when CondExR=1, bit-group-wise per FlagW.

Output gating:
- RegWrite = RegW & CondExR & (Rd≠15).
- MemWrite = MemW & CondExR.
- PCWrite = NextPC | (Branch & CondExR) | (RegW & CondExR & Rd==15).

Test Plan:
- Reset: rst=1 for 2 cycles with FETCH-level stimulus → State=0, all write enables 0, Flags=0; release rst → IRWrite=1 and PCWrite=1 in the first cycle.
- ADD R1, register operands, Op=00, Funct=001000, Cond=1110 → States 0,1,6,8; RegWrite=1 only in the ALUWB cycle; ALUControl=00 in EXECUTER; Flags unchanged.
- SUBS with Funct=000101 and ALUFlags=0100 → Flags=0100 after EXECUTER; then BNE (Op=10, Cond=0001) → States 0,1,9 with PCWrite=1 only in FETCH; BEQ → PCWrite=1 in BRANCH.
- LDR with Funct=011001 → States 0,1,2,3,4; AdrSrc=1 in MEMREAD; RegWrite=1 in MEMWB. STREQ with Z=0 → States 0,1,2,5; MemWrite=0 throughout.
- CMP (Funct=010101) with ALUFlags=0110 → RegWrite never asserted; Flags=0110. ADD with Rd=15 → RegWrite=0 and PCWrite=1 in ALUWB.
- Reset mid-LDR (rst=1 during MEMREAD) → next State=0, no RegWrite. COND_FULL=0 build with Cond=1010 → no writes.
